// File: rtl/sptx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_t       : transmitter FSM encoding (IDLE, SHIFT, GAP_WAIT)
//   IDLE_LEVEL    : level held on the serial line between words
//   PAT_A/PAT_B   : detection patterns as windows {b5..b0}, b0 = current bit
//   window_match  : compares the low 'len' bits of a line window to a pattern
package sptx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        GAP_WAIT = 2'd2
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // History depth of the predictor; the window adds the current bit on top.
    localparam int HIST_LEN = 5;
    localparam int WIN_W    = HIST_LEN + 1;

    // Pattern 0100 (rightmost first): (b3,b2,b1,b0) = (0,0,1,0).
    localparam int               PAT_A_LEN = 4;
    localparam logic [WIN_W-1:0] PAT_A     = 6'b00_0010;

    // Pattern 00010 (rightmost first): (b4,b3,b2,b1,b0) = (0,1,0,0,0).
    localparam int               PAT_B_LEN = 5;
    localparam logic [WIN_W-1:0] PAT_B     = 6'b00_1000;

    function automatic logic window_match(input logic [WIN_W-1:0] window,
                                          input logic [WIN_W-1:0] pattern,
                                          input int               len);
        logic [WIN_W-1:0] mask;
        mask = WIN_W'((1 << len) - 1);
        return (window & mask) == (pattern & mask);
    endfunction

endpackage

// File: rtl/serial_pattern_predict.sv
// Line-pattern predictor for the serial pattern transmitter.
// Keeps a 5-bit history of the serial line and flags, with zero latency,
// every cycle in which the current bit completes one of the two patterns.
// Ports:
//   clk         : clock
//   reset       : synchronous active-low reset (history -> all ones)
//   line        : current serial line level
//   expect_flag : combinational predicted match
module serial_pattern_predict
    import sptx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic expect_flag
);

    // hist[0] is the bit driven one cycle ago, hist[HIST_LEN-1] the oldest.
    logic [HIST_LEN-1:0] hist;
    logic [WIN_W-1:0]    window;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist <= '1;
        end else begin
            hist <= {hist[HIST_LEN-2:0], line};
        end
    end

    assign window      = {hist, line};
    assign expect_flag = window_match(window, PAT_A, PAT_A_LEN)
                       | window_match(window, PAT_B, PAT_B_LEN);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts parallel words over load/ready and
// shifts each out LSB-first on 'out', idle-high between words, with GAP
// extra idle cycles enforced after every word.
// Optional feature macro: SPTX_PREDICT_EN (enables the pattern predictor;
// when undefined expect_flag is tied low).
// Ports:
//   clk         : clock, all state changes on posedge
//   reset       : synchronous active-low reset, priority over load
//   data_in     : word to transmit, sampled on an accepted load
//   load        : word valid
//   ready       : high when a word can be accepted
//   out         : serial line, idle level 1
//   done        : one-cycle pulse while the last bit is on the line
//   expect_flag : predicted pattern match on the line
module serial_pattern_tx
    import sptx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             done,
    output logic             expect_flag
);

    localparam int                CNT_W        = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  NEXT_TO_LAST = CNT_W'(WIDTH - 2);
    localparam logic [3:0]        GAP_LAST     = 4'(GAP > 0 ? GAP - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;   // index of the bit currently on 'out'
    logic [3:0]       gap_cnt;
    logic [WIDTH-1:0] shreg;     // shreg[0] is the bit currently on 'out'

    // NOTE: all registered state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            out     <= IDLE_LEVEL;
            ready   <= 1'b1;
            done    <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        shreg   <= data_in;
                        out     <= data_in[0];
                        bit_cnt <= '0;
                        ready   <= 1'b0;
                        state   <= SHIFT;
                    end else begin
                        out   <= IDLE_LEVEL;
                        ready <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        out     <= IDLE_LEVEL;
                        done    <= 1'b0;
                        bit_cnt <= '0;
                        if (GAP > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP_WAIT;
                        end else begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= shreg >> 1;
                        out     <= shreg[1];
                        // The next bit on the line is the MSB.
                        done    <= (bit_cnt == NEXT_TO_LAST);
                    end
                end

                GAP_WAIT: begin
                    out <= IDLE_LEVEL;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                default: begin
                    out   <= IDLE_LEVEL;
                    ready <= 1'b1;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPTX_PREDICT_EN
    serial_pattern_predict u_predict (
        .clk         (clk),
        .reset       (reset),
        .line        (out),
        .expect_flag (expect_flag)
    );
`else
    assign expect_flag = 1'b0;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: two instances (GAP=0 and GAP=2) share
// the same stimulus and are compared every cycle against a timeline model
// (offset of the current edge from the accepting edge), plus directed
// checks of the documented scenarios and a randomized run.
module tb_serial_pattern_tx;

    localparam int W = 8;

`ifdef SPTX_PREDICT_EN
    localparam logic [W-1:0] H04_FLAGS = 8'b0010_1000;
`else
    localparam logic [W-1:0] H04_FLAGS = 8'h00;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;

    logic out0, ready0, done0, flag0;
    logic out2, ready2, done2, flag2;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(W), .GAP(0)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .load        (load),
        .ready       (ready0),
        .out         (out0),
        .done        (done0),
        .expect_flag (flag0)
    );

    serial_pattern_tx #(.WIDTH(W), .GAP(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .load        (load),
        .ready       (ready2),
        .out         (out2),
        .done        (done2),
        .expect_flag (flag2)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: phase = edges since the word was accepted, -1 = idle.
    int           phase [2] = '{-1, -1};
    int           gapv  [2] = '{0, 2};
    logic [W-1:0] mword [2];
    logic [4:0]   mhist [2] = '{5'b11111, 5'b11111};
    logic         mout  [2] = '{1'b1, 1'b1};

    task automatic model_edge(input int i, input logic rst, input logic ld, input logic [W-1:0] d);
        if (!rst) begin
            phase[i] = -1;
            mhist[i] = 5'b11111;
            mout[i]  = 1'b1;
        end else begin
            mhist[i] = {mhist[i][3:0], mout[i]};
            if (phase[i] == -1) begin
                if (ld) begin
                    phase[i] = 0;
                    mword[i] = d;
                end
            end else begin
                phase[i]++;
                if (phase[i] == W + gapv[i]) phase[i] = -1;
            end
            mout[i] = (phase[i] >= 0 && phase[i] < W) ? mword[i][phase[i]] : 1'b1;
        end
    endtask

    function automatic logic model_flag(input int i);
`ifdef SPTX_PREDICT_EN
        logic [4:0] seq;   // {b4,b3,b2,b1,b0}, b0 = bit now on the line
        seq = {mhist[i][3:0], mout[i]};
        return (seq[3:0] == 4'b0010) || (seq == 5'b01000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all();
        check("g0/out",   out0,   mout[0]);
        check("g0/ready", ready0, phase[0] == -1);
        check("g0/done",  done0,  phase[0] == W - 1);
        check("g0/flag",  flag0,  model_flag(0));
        check("g2/out",   out2,   mout[1]);
        check("g2/ready", ready2, phase[1] == -1);
        check("g2/done",  done2,  phase[1] == W - 1);
        check("g2/flag",  flag2,  model_flag(1));
    endtask

    // One clock edge: model consumes the pre-edge inputs, DUTs are sampled #1 later.
    task automatic step();
        logic         r, l;
        logic [W-1:0] d;
        r = reset;
        l = load;
        d = data_in;
        @(posedge clk);
        model_edge(0, r, l, d);
        model_edge(1, r, l, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        load = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [W-1:0] bits, dones, flags;

        // Reset held two cycles, then ten idle cycles.
        reset = 1'b0;
        step();
        step();
        check("rst/out",   out0,   1'b1);
        check("rst/ready", ready0, 1'b1);
        check("rst/done",  done0,  1'b0);
        check("rst/flag",  flag0,  1'b0);
        reset = 1'b1;
        idle(10);
        check("idle/out",   out0,   1'b1);
        check("idle/ready", ready0, 1'b1);

        // Word 8'h04: bit sequence, done and flag positions.
        data_in = 8'h04;
        load    = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i > 0) step();
            bits[i]  = out0;
            dones[i] = done0;
            flags[i] = flag0;
        end
        check("h04/seq",  bits,  8'h04);
        check("h04/done", dones, 8'h80);
        check("h04/flag", flags, H04_FLAGS);
        step();
        check("h04/done_end", done0, 1'b0);
        check("h04/line_end", out0,  1'b1);
        idle(4);

        // Load held: 8'hA5 then 8'h3C.
        data_in = 8'hA5;
        load    = 1'b1;
        step();
        data_in = 8'h3C;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 8) begin
                check("hold/gap_bit",    out0,   1'b1);
                check("hold/ready_gap",  ready0, 1'b1);
            end
            if (e == 9) begin
                check("hold/second_lsb", out0,   1'b0);
                check("hold/busy",       ready0, 1'b0);
            end
        end
        idle(12);

        // All ones: the line never leaves idle level, no prediction.
        data_in = 8'hFF;
        load    = 1'b1;
        step();
        load = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("ff/out",  out0,  1'b1);
            check("ff/flag", flag0, 1'b0);
        end

        // Reset in the middle of 8'h55, then a clean restart with 8'hAA.
        data_in = 8'h55;
        load    = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check("midrst/out",   out0,   1'b1);
        check("midrst/ready", ready0, 1'b1);
        check("midrst/done",  done0,  1'b0);
        check("midrst/flag",  flag0,  1'b0);
        reset   = 1'b1;
        data_in = 8'hAA;
        load    = 1'b1;
        step();
        check("restart/lsb",   out0,   1'b0);
        check("restart/ready", ready0, 1'b0);
        load = 1'b0;
        step();
        check("restart/bit1",  out0,   1'b1);
        idle(12);

        // GAP=2, back-to-back words on dut2.
        data_in = 8'hC3;
        load    = 1'b1;
        step();
        data_in = 8'h5A;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e >= 8 && e <= 10) check("gap2/idle_bit", out2, 1'b1);
            if (e == 8 || e == 9)  check("gap2/ready_low", ready2, 1'b0);
            if (e == 10)           check("gap2/ready_up",  ready2, 1'b1);
            if (e == 11)           check("gap2/next_lsb",  out2, 1'b0);
        end
        idle(20);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 99) != 0);
            load    = ($urandom_range(0, 2) != 0);
            data_in = W'($urandom);
            step();
        end
        idle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
